// File: rtl/npu_ahb_img_loader.sv
// npu_ahb_img_loader: AHB-Lite master that streams packed RGB pixels into the NPU, commits rows and polls for the predicted class
module npu_ahb_img_loader #(
  parameter logic [31:0] RGB_BASE     = 32'h0000_0000,
  parameter logic [31:0] CTRL_ADDR    = 32'h0000_4000,
  parameter logic [31:0] STATUS_ADDR  = 32'h0000_4004,
  parameter int          DONE_BIT     = 0,
  parameter int          CLASS_LSB    = 1,
  parameter int          ROW_WORDS    = 24,
  parameter int          NUM_ROWS     = 32,
  parameter int          POLL_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        pix_valid_i,
  input  logic [31:0] pix_data_i,
  output logic        pix_ready_o,
  output logic [31:0] ahb_m0_haddr_o,
  output logic        ahb_m0_hwrite_o,
  output logic [2:0]  ahb_m0_hsize_o,
  output logic [2:0]  ahb_m0_hburst_o,
  output logic [3:0]  ahb_m0_hprot_o,
  output logic [1:0]  ahb_m0_htrans_o,
  output logic        ahb_m0_hmastlock_o,
  output logic [31:0] ahb_m0_hwdata_o,
  input  logic        ahb_m0_hready_i,
  input  logic        ahb_m0_hresp_i,
  input  logic [31:0] ahb_m0_hrdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [4:0]  class_o,
  output logic        error_o
);
  typedef enum logic [3:0] {IDLE, WAIT_PIX, PIX_ADDR, PIX_DATA, ROW_ADDR, ROW_DATA, POLL_ADDR, POLL_DATA, DONE, ERR} state_t;
  localparam logic [1:0] HT_IDLE = 2'b00;
  localparam logic [1:0] HT_NSEQ = 2'b10;
  state_t state;
  logic [15:0] word_cnt, row_cnt, poll_cnt;
  logic [31:0] wdata_r, pix_addr;
  logic data_done, timeout, fault, unused_ok;
  assign ahb_m0_hsize_o = 3'b010;
  assign ahb_m0_hburst_o = 3'b000;
  assign ahb_m0_hprot_o = 4'b0011;
  assign ahb_m0_hmastlock_o = 1'b0;
  assign unused_ok = ^ahb_m0_hrdata_i;
  always_comb begin
    pix_addr = RGB_BASE + ((32'(row_cnt) * 32'(ROW_WORDS) + 32'(word_cnt)) << 2);
    data_done = ahb_m0_hready_i && (state inside {PIX_DATA, ROW_DATA, POLL_DATA});
    timeout = data_done && state == POLL_DATA && !ahb_m0_hresp_i && !ahb_m0_hrdata_i[DONE_BIT] && poll_cnt == 16'(POLL_TIMEOUT - 1);
    fault = (data_done && ahb_m0_hresp_i) || timeout;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      word_cnt <= '0;
      row_cnt <= '0;
      poll_cnt <= '0;
      wdata_r <= '0;
      pix_ready_o <= 1'b0;
      ahb_m0_haddr_o <= '0;
      ahb_m0_hwrite_o <= 1'b0;
      ahb_m0_htrans_o <= HT_IDLE;
      ahb_m0_hwdata_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      class_o <= '0;
      error_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (fault) begin
        state <= ERR;
        error_o <= 1'b1;
        busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE, ERR: if (start_i) begin
            state <= WAIT_PIX;
            word_cnt <= '0;
            row_cnt <= '0;
            poll_cnt <= '0;
            error_o <= 1'b0;
            busy_o <= 1'b1;
            pix_ready_o <= 1'b1;
          end
          WAIT_PIX: if (pix_valid_i) begin
            state <= PIX_ADDR;
            pix_ready_o <= 1'b0;
            wdata_r <= pix_data_i;
            ahb_m0_htrans_o <= HT_NSEQ;
            ahb_m0_hwrite_o <= 1'b1;
            ahb_m0_haddr_o <= pix_addr;
          end
          PIX_ADDR: if (ahb_m0_hready_i) begin
            state <= PIX_DATA;
            ahb_m0_htrans_o <= HT_IDLE;
            ahb_m0_hwdata_o <= wdata_r;
          end
          PIX_DATA: if (ahb_m0_hready_i) begin
            word_cnt <= word_cnt + 16'd1;
            if (word_cnt == 16'(ROW_WORDS - 1)) begin
              state <= ROW_ADDR;
              ahb_m0_htrans_o <= HT_NSEQ;
              ahb_m0_hwrite_o <= 1'b1;
              ahb_m0_haddr_o <= CTRL_ADDR;
            end else begin
              state <= WAIT_PIX;
              pix_ready_o <= 1'b1;
            end
          end
          ROW_ADDR: if (ahb_m0_hready_i) begin
            state <= ROW_DATA;
            ahb_m0_htrans_o <= HT_IDLE;
            ahb_m0_hwdata_o <= 32'h1;
          end
          ROW_DATA: if (ahb_m0_hready_i) begin
            row_cnt <= row_cnt + 16'd1;
            word_cnt <= '0;
            if (row_cnt == 16'(NUM_ROWS - 1)) begin
              state <= POLL_ADDR;
              ahb_m0_htrans_o <= HT_NSEQ;
              ahb_m0_hwrite_o <= 1'b0;
              ahb_m0_haddr_o <= STATUS_ADDR;
            end else begin
              state <= WAIT_PIX;
              pix_ready_o <= 1'b1;
            end
          end
          POLL_ADDR: if (ahb_m0_hready_i) begin
            state <= POLL_DATA;
            ahb_m0_htrans_o <= HT_IDLE;
          end
          POLL_DATA: if (ahb_m0_hready_i) begin
            if (ahb_m0_hrdata_i[DONE_BIT]) begin
              state <= DONE;
              class_o <= ahb_m0_hrdata_i[CLASS_LSB +: 5];
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end else begin
              state <= POLL_ADDR;
              poll_cnt <= poll_cnt + 16'd1;
              ahb_m0_htrans_o <= HT_NSEQ;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_npu_ahb_img_loader.sv
// tb_npu_ahb_img_loader: transaction-level model and scoreboard for the AHB image loader
module tb_npu_ahb_img_loader;
  localparam int RW = 2;
  localparam int NR = 2;
  localparam int PT = 4;
  localparam logic [31:0] CTRL = 32'h0000_4000;
  localparam logic [31:0] STAT = 32'h0000_4004;
  typedef struct packed {logic [31:0] addr; logic wr; logic [31:0] data;} xfer_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start_i = 1'b0;
  logic pix_valid_i = 1'b0;
  logic [31:0] pix_data_i = '0;
  logic pix_ready_o;
  logic [31:0] haddr, hwdata;
  logic [31:0] hrdata = '0;
  logic hwrite, hmastlock;
  logic hready = 1'b1;
  logic hresp = 1'b0;
  logic [2:0] hsize, hburst;
  logic [3:0] hprot;
  logic [1:0] htrans;
  logic busy_o, done_o, error_o;
  logic [4:0] class_o;
  int tests = 0;
  int fails = 0;
  xfer_t exp_q[$];
  xfer_t se;
  logic [31:0] status_q[$];
  logic [31:0] pix[$];
  int hs_cyc[$];
  int ws = 0, err_idx = -1, pix_wr_cnt = 0, n_reads = 0, n_xfers = 0, wait_left = 0;
  bit astall = 0, dphase = 0, stalled = 0, first = 0, cur_wr = 0, inject = 0;
  logic [31:0] cur_addr = '0, cur_data = '0, saddr = '0;
  int pidx = 0, pmode = 0, cyc = 0, done_cnt = 0;
  bit phase = 0, hs = 0;
  logic [4:0] exp_class = '0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  npu_ahb_img_loader #(.ROW_WORDS(RW), .NUM_ROWS(NR), .POLL_TIMEOUT(PT)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i),
    .pix_valid_i(pix_valid_i), .pix_data_i(pix_data_i), .pix_ready_o(pix_ready_o),
    .ahb_m0_haddr_o(haddr), .ahb_m0_hwrite_o(hwrite), .ahb_m0_hsize_o(hsize),
    .ahb_m0_hburst_o(hburst), .ahb_m0_hprot_o(hprot), .ahb_m0_htrans_o(htrans),
    .ahb_m0_hmastlock_o(hmastlock), .ahb_m0_hwdata_o(hwdata),
    .ahb_m0_hready_i(hready), .ahb_m0_hresp_i(hresp), .ahb_m0_hrdata_i(hrdata),
    .busy_o(busy_o), .done_o(done_o), .class_o(class_o), .error_o(error_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic xfer_t mk(input logic [31:0] a, input logic w, input logic [31:0] d);
    xfer_t x;
    x.addr = a;
    x.wr = w;
    x.data = d;
    return x;
  endfunction
  task automatic build(input int nreads);
    exp_q.delete();
    for (int r = 0; r < NR; r++) begin
      for (int w = 0; w < RW; w++) exp_q.push_back(mk(32'(4 * (r * RW + w)), 1'b1, pix[r * RW + w]));
      exp_q.push_back(mk(CTRL, 1'b1, 32'h1));
    end
    for (int i = 0; i < nreads; i++) exp_q.push_back(mk(STAT, 1'b0, 32'h0));
  endtask
  task automatic setup(input logic [31:0] p0, input int mode, input int w, input bit st, input int ei);
    @(posedge clk);
    #1;
    pix.delete();
    for (int i = 0; i < RW * NR; i++) pix.push_back(p0 + 32'(i));
    pidx = 0;
    pmode = mode;
    ws = w;
    astall = st;
    err_idx = ei;
    pix_wr_cnt = 0;
    n_reads = 0;
    n_xfers = 0;
    done_cnt = 0;
    hs_cyc.delete();
    status_q.delete();
    exp_q.delete();
  endtask
  task automatic pulse_start();
    @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask
  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!done_o && !error_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      tests++;
      fails++;
      $display("FAIL %s: no done or error within 2000 cycles", name);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_outputs(input string name);
    chk({name, "_haddr"}, haddr, 32'h0);
    chk({name, "_hwdata"}, hwdata, 32'h0);
    chk({name, "_ctl"}, 32'({htrans, hwrite, pix_ready_o, busy_o, done_o, class_o, error_o}), 32'h0);
  endtask
  initial forever begin
    @(negedge clk);
    hresp = 1'b0;
    if (!resetn) begin
      dphase = 0;
      stalled = 0;
      hready = 1'b1;
    end else if (dphase) begin
      if (first) begin
        cur_data = hwdata;
        first = 0;
      end else if (cur_wr) chk("hwdata_stable", hwdata, cur_data);
      if (wait_left > 0) begin
        hready = 1'b0;
        wait_left--;
      end else begin
        hready = 1'b1;
        dphase = 0;
        inject = 0;
        if (cur_wr && cur_addr < CTRL) begin
          inject = pix_wr_cnt == err_idx;
          pix_wr_cnt++;
        end
        hresp = inject;
        if (!cur_wr) begin
          if (status_q.size() > 0) hrdata = status_q.pop_front();
          else hrdata = 32'h0;
          n_reads++;
        end
        n_xfers++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_xfer: got addr %h write %0d, none required", cur_addr, cur_wr);
        end else begin
          se = exp_q.pop_front();
          chk("xfer_addr", cur_addr, se.addr);
          chk("xfer_write", 32'(cur_wr), 32'(se.wr));
          if (se.wr) chk("xfer_data", cur_data, se.data);
        end
      end
    end else begin
      hready = 1'b1;
      if (htrans == 2'b10) begin
        if (astall && !stalled) begin
          hready = 1'b0;
          stalled = 1;
          saddr = haddr;
        end else begin
          if (stalled) chk("haddr_held", haddr, saddr);
          stalled = 0;
          dphase = 1;
          first = 1;
          cur_addr = haddr;
          cur_wr = hwrite;
          wait_left = ws;
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (!resetn) hs = 0;
    if (hs) begin
      pidx++;
      hs_cyc.push_back(cyc);
    end
    phase = !phase;
    pix_valid_i = pidx < pix.size() && (pmode == 0 || phase);
    pix_data_i = pidx < pix.size() ? pix[pidx] : 32'h0;
    hs = pix_valid_i && pix_ready_o && resetn;
  end
  initial forever begin
    @(negedge clk);
    if (resetn && htrans == 2'b10) chk("fixed_ahb", 32'({hsize, hburst, hprot, hmastlock}), 32'({3'b010, 3'b000, 4'b0011, 1'b0}));
    if (resetn && done_o) begin
      done_cnt++;
      chk("done_class", 32'(class_o), 32'(exp_class));
      chk("done_busy", 32'(busy_o), 32'h0);
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("rst0");
    @(negedge clk);
    resetn = 1'b1;
    setup(32'hA0, 0, 0, 0, -1);
    status_q = '{32'h0, 32'h0, 32'h15};
    exp_class = 5'd10;
    build(3);
    pulse_start();
    wait_end("t1");
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_class", 32'(class_o), 32'd10);
    chk("t1_reads", 32'(n_reads), 32'd3);
    chk("t1_xfers", 32'(n_xfers), 32'd9);
    chk("t1_left", 32'(exp_q.size()), 32'd0);
    chk("t1_pix_gap", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
    chk("t1_busy_err", 32'({busy_o, error_o}), 32'h0);
    setup(32'hB0, 0, 3, 1, -1);
    status_q = '{32'h0F};
    exp_class = 5'd7;
    build(1);
    pulse_start();
    wait_end("t2");
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);
    chk("t2_class", 32'(class_o), 32'd7);
    chk("t2_xfers", 32'(n_xfers), 32'd7);
    chk("t2_left", 32'(exp_q.size()), 32'd0);
    setup(32'hC0, 1, 0, 0, -1);
    status_q = '{32'h0, 32'h3F};
    exp_class = 5'd31;
    build(2);
    pulse_start();
    wait_end("t3");
    chk("t3_done_cnt", 32'(done_cnt), 32'd1);
    chk("t3_class", 32'(class_o), 32'd31);
    chk("t3_pix_used", 32'(pidx), 32'd4);
    chk("t3_left", 32'(exp_q.size()), 32'd0);
    setup(32'hD0, 0, 0, 0, 1);
    exp_q.push_back(mk(32'h0, 1'b1, 32'hD0));
    exp_q.push_back(mk(32'h4, 1'b1, 32'hD1));
    pulse_start();
    wait_end("t4");
    chk("t4_err_state", 32'({error_o, busy_o, htrans, pix_ready_o}), 32'b10000);
    chk("t4_done_cnt", 32'(done_cnt), 32'd0);
    chk("t4_left", 32'(exp_q.size()), 32'd0);
    setup(32'hE0, 0, 0, 0, -1);
    status_q = '{32'h0B};
    exp_class = 5'd5;
    build(1);
    pulse_start();
    chk("t4r_err_clr", 32'(error_o), 32'h0);
    wait_end("t4r");
    chk("t4r_done_cnt", 32'(done_cnt), 32'd1);
    chk("t4r_class", 32'(class_o), 32'd5);
    chk("t4r_xfers", 32'(n_xfers), 32'd7);
    chk("t4r_left", 32'(exp_q.size()), 32'd0);
    setup(32'hF0, 0, 0, 0, -1);
    build(4);
    pulse_start();
    wait_end("t5");
    repeat (10) @(posedge clk);
    #1;
    chk("t5_reads", 32'(n_reads), 32'd4);
    chk("t5_err_busy", 32'({error_o, busy_o}), 32'b10);
    chk("t5_done_cnt", 32'(done_cnt), 32'd0);
    chk("t5_left", 32'(exp_q.size()), 32'd0);
    setup(32'h10, 0, 3, 0, -1);
    build(1);
    pulse_start();
    n = 0;
    while (!(dphase && cur_wr && cur_addr == 32'h4) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t6_reached_pix_data", 32'(n < 200), 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk_reset_outputs("t6_rst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    setup(32'h20, 0, 0, 0, -1);
    status_q = '{32'h13};
    exp_class = 5'd9;
    build(1);
    pulse_start();
    wait_end("t6");
    chk("t6_done_cnt", 32'(done_cnt), 32'd1);
    chk("t6_class", 32'(class_o), 32'd9);
    chk("t6_xfers", 32'(n_xfers), 32'd7);
    chk("t6_left", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
